pcpu_mem_server: RTL and testbench

- Memory-side responder for the pipelined CPU's instruction and data ports.
- Holds 256x16 instruction RAM and 256x16 data RAM.
  - Serves CPU fetch and load with combinational reads.
  - Serves CPU store with a synchronous write.
- Host-side valid/ready command port loads programs and reads results.
- Before every host access it pauses the CPU via cpu_enable and waits for cpu_run low.

---
 rtl/pcpu_mem_server_pkg.sv | 23 ++
 rtl/pcpu_ram.sv | 29 ++
 rtl/pcpu_mem_server.sv | 140 ++++++++++++++
 tb/tb_pcpu_mem_server.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_mem_server_pkg.sv
// Shared constants and types for the CPU memory server: widths, host command
// op encodings and the host-access FSM states.
package pcpu_mem_server_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    // Bit 1 set means read, bit 0 set selects the data RAM
    typedef enum logic [1:0] {
        OP_WR_IMEM = 2'b00,
        OP_WR_DMEM = 2'b01,
        OP_RD_IMEM = 2'b10,
        OP_RD_DMEM = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/pcpu_ram.sv
// Word-addressed RAM with two combinational read ports and one synchronous
// write port; contents are never reset.
module pcpu_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/pcpu_mem_server.sv
// Instruction/data memory responder for the pipelined CPU, with a host command
// port that pauses the CPU before every host access.
module pcpu_mem_server
    import pcpu_mem_server_pkg::*;
#(
    parameter int ADDR_W = pcpu_mem_server_pkg::ADDR_W,
    parameter int DATA_W = pcpu_mem_server_pkg::DATA_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_datain,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_dataout,
    output logic [DATA_W-1:0] d_datain,
    input  logic              cpu_run,
    output logic              cpu_enable,
    input  logic              host_en,
    input  logic              h_cmd_valid,
    output logic              h_cmd_ready,
    input  logic [1:0]        h_cmd_op,
    input  logic [ADDR_W-1:0] h_cmd_addr,
    input  logic [DATA_W-1:0] h_cmd_wdata,
    output logic              h_rsp_valid,
    input  logic              h_rsp_ready,
    output logic [DATA_W-1:0] h_rsp_data,
    output logic              busy
);

    state_e            state_q;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              host_wr;
    logic              imem_we;
    logic              dmem_we;
    logic              cpu_wr;
    logic [ADDR_W-1:0] dmem_waddr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] imem_host_rd;
    logic [DATA_W-1:0] dmem_host_rd;

    assign h_cmd_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);

    // Host writes land on the single ACCESS edge; on the data RAM the host wins
    assign host_wr    = (state_q == ACCESS) && !op_q[1];
    assign imem_we    = host_wr && (op_q == OP_WR_IMEM);
    assign cpu_wr     = d_we && cpu_run;
    assign dmem_we    = (host_wr && (op_q == OP_WR_DMEM)) || cpu_wr;
    assign dmem_waddr = (host_wr && (op_q == OP_WR_DMEM)) ? addr_q  : d_addr;
    assign dmem_wdata = (host_wr && (op_q == OP_WR_DMEM)) ? wdata_q : d_dataout;

    pcpu_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) imem (
        .clock   (clock),
        .we      (imem_we),
        .waddr   (addr_q),
        .wdata   (wdata_q),
        .raddr_a (i_addr),
        .rdata_a (i_datain),
        .raddr_b (addr_q),
        .rdata_b (imem_host_rd)
    );

    pcpu_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dmem (
        .clock   (clock),
        .we      (dmem_we),
        .waddr   (dmem_waddr),
        .wdata   (dmem_wdata),
        .raddr_a (d_addr),
        .rdata_a (d_datain),
        .raddr_b (addr_q),
        .rdata_b (dmem_host_rd)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= OP_WR_IMEM;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_enable  <= 1'b0;
            h_rsp_valid <= 1'b0;
            h_rsp_data  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cpu_enable <= host_en;
                    if (h_cmd_valid) begin
                        op_q       <= op_e'(h_cmd_op);
                        addr_q     <= h_cmd_addr;
                        wdata_q    <= h_cmd_wdata;
                        cpu_enable <= 1'b0;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    cpu_enable <= 1'b0;
                    if (!cpu_run) begin
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    cpu_enable  <= 1'b0;
                    h_rsp_valid <= 1'b1;
                    state_q     <= RESP;
                    if (!op_q[1]) begin
                        h_rsp_data <= wdata_q;
                    end else if (op_q[0]) begin
                        h_rsp_data <= dmem_host_rd;
                    end else begin
                        h_rsp_data <= imem_host_rd;
                    end
                end
                RESP: begin
                    cpu_enable <= 1'b0;
                    if (h_rsp_ready) begin
                        h_rsp_valid <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcpu_mem_server.sv
// Directed and randomized checks of pcpu_mem_server against a simple array
// model of both RAMs and the documented host-command latency.
module tb_pcpu_mem_server;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  i_addr;
    logic [15:0] i_datain;
    logic [7:0]  d_addr;
    logic        d_we;
    logic [15:0] d_dataout;
    logic [15:0] d_datain;
    logic        cpu_run;
    logic        cpu_enable;
    logic        host_en;
    logic        h_cmd_valid;
    logic        h_cmd_ready;
    logic [1:0]  h_cmd_op;
    logic [7:0]  h_cmd_addr;
    logic [15:0] h_cmd_wdata;
    logic        h_rsp_valid;
    logic        h_rsp_ready;
    logic [15:0] h_rsp_data;
    logic        busy;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [15:0] imemModel [256];
    logic [15:0] dmemModel [256];
    logic [7:0]  imemWritten [$];
    logic [7:0]  dmemWritten [$];

    pcpu_mem_server dut (
        .clock       (clock),
        .reset       (reset),
        .i_addr      (i_addr),
        .i_datain    (i_datain),
        .d_addr      (d_addr),
        .d_we        (d_we),
        .d_dataout   (d_dataout),
        .d_datain    (d_datain),
        .cpu_run     (cpu_run),
        .cpu_enable  (cpu_enable),
        .host_en     (host_en),
        .h_cmd_valid (h_cmd_valid),
        .h_cmd_ready (h_cmd_ready),
        .h_cmd_op    (h_cmd_op),
        .h_cmd_addr  (h_cmd_addr),
        .h_cmd_wdata (h_cmd_wdata),
        .h_rsp_valid (h_rsp_valid),
        .h_rsp_ready (h_rsp_ready),
        .h_rsp_data  (h_rsp_data),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Model update for a completed host command
    task automatic modelHost(input logic [1:0] op, input logic [7:0] addr,
                             input logic [15:0] wdata);
        if (op == 2'b00) begin
            imemModel[addr] = wdata;
            imemWritten.push_back(addr);
        end else if (op == 2'b01) begin
            dmemModel[addr] = wdata;
            dmemWritten.push_back(addr);
        end
    endtask

    // One full host command; hold = cycles cpu_run stays high after accept
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] addr,
                                 input logic [15:0] wdata, input int hold,
                                 output logic [15:0] data, output int latency);
        int waitCount;
        waitCount = 0;
        while (!h_cmd_ready && waitCount < 20) begin
            tick();
            waitCount++;
        end
        if (!h_cmd_ready) checkOutput("cmd_ready_timeout", {31'd0, h_cmd_ready}, 32'd1);
        h_cmd_valid = 1'b1;
        h_cmd_op    = op;
        h_cmd_addr  = addr;
        h_cmd_wdata = wdata;
        tick();
        h_cmd_valid = 1'b0;
        latency     = 0;
        cpu_run     = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            latency++;
        end
        cpu_run = 1'b0;
        while (!h_rsp_valid && latency < 50) begin
            tick();
            latency++;
        end
        if (!h_rsp_valid) checkOutput("rsp_valid_timeout", {31'd0, h_rsp_valid}, 32'd1);
        data        = h_rsp_data;
        h_rsp_ready = 1'b1;
        tick();
        h_rsp_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] data;
        int          latency;
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [15:0] wdata;
        int          hold;
        logic [15:0] expData;

        reset = 1'b0;
        i_addr = '0; d_addr = '0; d_we = 1'b0; d_dataout = '0;
        cpu_run = 1'b0; host_en = 1'b0;
        h_cmd_valid = 1'b0; h_cmd_op = '0; h_cmd_addr = '0; h_cmd_wdata = '0;
        h_rsp_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        checkOutput("reset_cmd_ready", {31'd0, h_cmd_ready}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_cpu_enable", {31'd0, cpu_enable}, 32'd0);
        checkOutput("reset_rsp_valid", {31'd0, h_rsp_valid}, 32'd0);
        checkOutput("reset_rsp_data", {16'd0, h_rsp_data}, 32'd0);

        // Directed imem write with explicit per-edge latency checks
        h_cmd_valid = 1'b1; h_cmd_op = 2'b00; h_cmd_addr = 8'h05; h_cmd_wdata = 16'h1234;
        tick();
        h_cmd_valid = 1'b0;
        checkOutput("accept_ready_low", {31'd0, h_cmd_ready}, 32'd0);
        checkOutput("accept_busy", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("e1_rsp_valid", {31'd0, h_rsp_valid}, 32'd0);
        tick();
        checkOutput("e2_rsp_valid", {31'd0, h_rsp_valid}, 32'd1);
        checkOutput("e2_rsp_data", {16'd0, h_rsp_data}, 32'h1234);
        h_rsp_ready = 1'b1;
        tick();
        h_rsp_ready = 1'b0;
        checkOutput("resp_done_valid", {31'd0, h_rsp_valid}, 32'd0);
        checkOutput("resp_done_ready", {31'd0, h_cmd_ready}, 32'd1);
        modelHost(2'b00, 8'h05, 16'h1234);
        i_addr = 8'h05;
        #1;
        checkOutput("imem05_fetch", {16'd0, i_datain}, 32'h1234);

        applyStimulus(2'b01, 8'h10, 16'hBEEF, 0, data, latency);
        modelHost(2'b01, 8'h10, 16'hBEEF);
        checkOutput("wr_dmem_echo", {16'd0, data}, 32'hBEEF);
        applyStimulus(2'b11, 8'h10, 16'h0000, 0, data, latency);
        checkOutput("rd_dmem10", {16'd0, data}, 32'hBEEF);
        checkOutput("rd_idle_latency", latency, 32'd2);
        d_addr = 8'h10;
        #1;
        checkOutput("dmem10_load", {16'd0, d_datain}, 32'hBEEF);

        // CPU running: host_en passes through in IDLE, held off during command
        host_en = 1'b1;
        tick();
        checkOutput("idle_cpu_enable", {31'd0, cpu_enable}, 32'd1);
        h_cmd_valid = 1'b1; h_cmd_op = 2'b10; h_cmd_addr = 8'h05;
        cpu_run = 1'b1;
        tick();
        h_cmd_valid = 1'b0;
        checkOutput("accept_cpu_enable", {31'd0, cpu_enable}, 32'd0);
        latency = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            latency++;
        end
        checkOutput("hold_busy", {31'd0, busy}, 32'd1);
        checkOutput("hold_no_rsp", {31'd0, h_rsp_valid}, 32'd0);
        cpu_run = 1'b0;
        while (!h_rsp_valid && latency < 50) begin
            tick();
            latency++;
        end
        checkOutput("run_latency", latency, 32'd5);
        checkOutput("run_rd_imem05", {16'd0, h_rsp_data}, 32'h1234);
        checkOutput("resp_cpu_enable", {31'd0, cpu_enable}, 32'd0);
        h_rsp_ready = 1'b1;
        tick();
        h_rsp_ready = 1'b0;
        tick();
        checkOutput("back_cpu_enable", {31'd0, cpu_enable}, 32'd1);
        host_en = 1'b0;
        tick();

        // CPU store is gated by cpu_run
        cpu_run = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_dataout = 16'h00AA;
        tick();
        cpu_run = 1'b0; d_dataout = 16'h5555;
        tick();
        d_we = 1'b0;
        dmemModel[8'h20] = 16'h00AA;
        dmemWritten.push_back(8'h20);
        #1;
        checkOutput("cpu_store_gated", {16'd0, d_datain}, 32'h00AA);

        // Response back-pressure with a second command pending
        h_cmd_valid = 1'b1; h_cmd_op = 2'b11; h_cmd_addr = 8'h10;
        tick();
        h_cmd_op = 2'b00; h_cmd_addr = 8'h33; h_cmd_wdata = 16'hDEAD;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_valid", {31'd0, h_rsp_valid}, 32'd1);
            checkOutput("stall_data", {16'd0, h_rsp_data}, 32'hBEEF);
            checkOutput("stall_ready", {31'd0, h_cmd_ready}, 32'd0);
            tick();
        end
        h_rsp_ready = 1'b1;
        tick();
        h_rsp_ready = 1'b0;
        h_cmd_valid = 1'b0;
        checkOutput("stall_release_idle", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("second_not_taken", {31'd0, busy}, 32'd0);

        // Reset while HOLDing a write must leave the RAM untouched
        applyStimulus(2'b00, 8'h01, 16'h0101, 0, data, latency);
        modelHost(2'b00, 8'h01, 16'h0101);
        host_en = 1'b1;
        cpu_run = 1'b1;
        h_cmd_valid = 1'b1; h_cmd_op = 2'b00; h_cmd_addr = 8'h01; h_cmd_wdata = 16'hFFFF;
        tick();
        h_cmd_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rst_hold_idle", {31'd0, h_cmd_ready}, 32'd1);
        checkOutput("rst_hold_rsp_valid", {31'd0, h_rsp_valid}, 32'd0);
        checkOutput("rst_hold_cpu_enable", {31'd0, cpu_enable}, 32'd0);
        cpu_run = 1'b0;
        host_en = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        i_addr = 8'h01;
        #1;
        checkOutput("rst_hold_imem01", {16'd0, i_datain}, 32'h0101);

        // Randomized host commands and CPU stores against the array model
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                addr = 8'($urandom);
                wdata = 16'($urandom);
                cpu_run = ($urandom_range(0, 1) == 1);
                d_we = 1'b1; d_addr = addr; d_dataout = wdata;
                if (cpu_run) begin
                    dmemModel[addr] = wdata;
                    dmemWritten.push_back(addr);
                end
                tick();
                d_we = 1'b0;
                cpu_run = 1'b0;
            end
            op = 2'($urandom_range(0, 3));
            if (op == 2'b10 && imemWritten.size() == 0) op = 2'b00;
            if (op == 2'b11 && dmemWritten.size() == 0) op = 2'b01;
            if (op == 2'b10) addr = imemWritten[$urandom_range(0, imemWritten.size() - 1)];
            else if (op == 2'b11) addr = dmemWritten[$urandom_range(0, dmemWritten.size() - 1)];
            else addr = 8'($urandom);
            wdata = 16'($urandom);
            hold = $urandom_range(0, 3);
            if (op == 2'b00) expData = wdata;
            else if (op == 2'b01) expData = wdata;
            else if (op == 2'b10) expData = imemModel[addr];
            else expData = dmemModel[addr];
            applyStimulus(op, addr, wdata, hold, data, latency);
            modelHost(op, addr, wdata);
            checkOutput("rand_rsp_data", {16'd0, data}, {16'd0, expData});
            checkOutput("rand_latency", latency, 32'(hold + 2));
        end

        foreach (imemWritten[k]) begin
            i_addr = imemWritten[k];
            #1;
            checkOutput("final_imem", {16'd0, i_datain}, {16'd0, imemModel[imemWritten[k]]});
        end
        foreach (dmemWritten[k]) begin
            d_addr = dmemWritten[k];
            #1;
            checkOutput("final_dmem", {16'd0, d_datain}, {16'd0, dmemModel[dmemWritten[k]]});
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
